// File: rtl/mips_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package mips_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  localparam int MD_ITER = 32;

endpackage

// File: rtl/mult_div_unit_step.sv
// One iteration of the unsigned magnitude datapath.
// Multiply: acc = {partial product high (with carry), multiplier bits not yet consumed}.
// Divide:   acc = {partial remainder, dividend bits / quotient bits}.
module md_iter_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0]   opnd_i,
  input  logic                is_div_i,
  output logic [2*DATA_W-1:0] acc_o
);

  logic [DATA_W:0]   sum;
  logic [2*DATA_W:0] sh;
  logic              ge;
  logic [DATA_W-1:0] diff;

  // Shift-add: the carry out of the add lands in the top bit before the right shift.
  assign sum  = {1'b0, acc_i[2*DATA_W-1:DATA_W]} + (acc_i[0] ? {1'b0, opnd_i} : '0);

  // Restoring divide: 33-bit partial remainder after the left shift.
  assign sh   = {acc_i, 1'b0};
  assign ge   = sh[2*DATA_W:DATA_W] >= {1'b0, opnd_i};
  // When ge holds the true difference is below 2^DATA_W, so a DATA_W-bit subtract suffices.
  assign diff = sh[2*DATA_W-1:DATA_W] - opnd_i;

  // Select the multiply or divide form of the next accumulator.
  always_comb begin
    acc_o = {sum, acc_i[DATA_W-1:1]};
    if (is_div_i) begin
      if (ge) acc_o = {diff, sh[DATA_W-1:1], 1'b1};
      else    acc_o = sh[2*DATA_W-1:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: 32-step iterative MULT/MULTU/DIV/DIVU on
// operand magnitudes with a final sign-fix cycle, plus single-cycle MTHI/MTLO.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int ACC_W = 2 * DATA_W;

  md_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_W-1:0]     acc_q, acc_d, acc_step;
  logic [DATA_W-1:0]    opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q_q, neg_q_d;   // quotient / product sign
  logic                 neg_r_q, neg_r_d;   // remainder sign
  logic [DATA_W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic                 is_iter, signed_op, a_neg, b_neg;
  logic [DATA_W-1:0]    a_mag, b_mag, quo, rem;
  logic [ACC_W-1:0]     prod;

  // Ops 0..3 are iterative; bit0 clear means signed, bit1 set means divide.
  assign is_iter   = (op[2] == 1'b0);
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & rs_data[DATA_W-1];
  assign b_neg     = signed_op & rt_data[DATA_W-1];
  // -2^31 negates to itself, which reads correctly as 2^31 unsigned.
  assign a_mag     = a_neg ? -rs_data : rs_data;
  assign b_mag     = b_neg ? -rt_data : rt_data;

  // Sign-corrected results, consumed in the fix cycle.
  assign quo  = neg_q_q ? -acc_q[DATA_W-1:0]     : acc_q[DATA_W-1:0];
  assign rem  = neg_r_q ? -acc_q[ACC_W-1:DATA_W] : acc_q[ACC_W-1:DATA_W];
  assign prod = neg_q_q ? -acc_q                 : acc_q;

  md_iter_step #(.DATA_W(DATA_W)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (acc_step)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          if (is_iter) begin
            is_div_d = op[1];
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = MD_RUN;
            if (op[1]) begin
              acc_d   = {{DATA_W{1'b0}}, a_mag};
              opnd_d  = b_mag;
              // A zero divisor leaves an all-ones quotient that must not be negated.
              neg_q_d = (a_neg ^ b_neg) & (rt_data != '0);
              neg_r_d = a_neg;
            end else begin
              acc_d   = {{DATA_W{1'b0}}, b_mag};
              opnd_d  = a_mag;
              neg_q_d = a_neg ^ b_neg;
              neg_r_d = 1'b0;
            end
          end else if (op == MD_MTHI) begin
            hi_d = rs_data;
          end else if (op == MD_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      MD_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MD_ITER - 1)) state_d = MD_FIX;
      end
      MD_FIX: begin
        if (is_div_q) begin
          lo_d = quo;
          hi_d = rem;
        end else begin
          hi_d = prod[ACC_W-1:DATA_W];
          lo_d = prod[DATA_W-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected {hi,lo}, a
// monitor pops and compares on every done pulse.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] hi_m, lo_m;

  mult_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    if (o == 3'd0 || o == 3'd2) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    if (o[1] == 1'b0) begin
      p = 64'(sa * sb);
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done hi=%h lo=%h with no pending op", hi, lo);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_hilo", {hi, lo}, mon_e);
      end
    end
  end

  // Iterative op; optionally fires MTLO 0x55 mid-operation, which must be dropped.
  task automatic issue_iter(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit inj);
    int n;
    logic [63:0] e;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    e = model(o, a, b);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (inj && n == 10) begin
        start = 1'b1; op = 3'd5; rs_data = 32'h55;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_len", 64'(n), 64'd33);
    chk("done_after_busy", 64'(done), 64'd1);
    @(negedge clk);
    chk("done_width", 64'(done), 64'd0);
    hi_m = e[63:32];
    lo_m = e[31:0];
  endtask

  // MTHI/MTLO or reserved op while idle.
  task automatic issue_mt(input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = $urandom;
    @(negedge clk);
    start = 1'b0;
    if (o == 3'd4) hi_m = a;
    if (o == 3'd5) lo_m = a;
    chk("mt_hilo", {hi, lo}, {hi_m, lo_m});
    chk("mt_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int dones, last;
    bit lower;
    logic [31:0] a, b;
    logic [2:0] o;
    int sel;

    rst_n = 1'b0; start = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
    hi_m = '0; lo_m = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {30'b0, busy, done, hi, lo}, 64'd0);
    rst_n = 1'b1;

    // Reset aborts MULT 5x7 mid-run.
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs_data = 32'd5; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_midop", {30'b0, busy, done, hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_result_after_abort", {hi, lo}, 64'd0);

    // Directed cases.
    issue_iter(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    issue_iter(3'd0, -32'sd3, 32'd7, 1'b0);
    chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    issue_iter(3'd0, 32'h80000000, 32'h80000000, 1'b0);
    chk("mult_minmin", {hi, lo}, 64'h40000000_00000000);
    issue_iter(3'd2, -32'sd7, 32'd2, 1'b0);
    chk("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue_iter(3'd3, 32'd100, 32'd7, 1'b0);
    chk("divu_basic", {hi, lo}, {32'd2, 32'd14});
    issue_iter(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("div_overflow", {hi, lo}, 64'h00000000_80000000);
    issue_iter(3'd2, 32'd1234, 32'd0, 1'b0);
    chk("div_by_zero", {hi, lo}, {32'd1234, 32'hFFFFFFFF});
    issue_iter(3'd2, -32'sd1234, 32'd0, 1'b0);
    chk("div_by_zero_neg", {hi, lo}, {-32'sd1234, 32'hFFFFFFFF});
    issue_mt(3'd4, 32'hDEADBEEF);
    chk("mthi_val", 64'(hi), 64'hDEADBEEF);
    issue_iter(3'd3, 32'd9, 32'd3, 1'b1);
    chk("mtlo_ignored_busy", {hi, lo}, {32'd0, 32'd3});
    issue_mt(3'd5, 32'h12345678);
    issue_mt(3'd6, 32'hCAFEF00D);
    issue_mt(3'd7, 32'hCAFEF00D);

    // Start held high: back-to-back ops, 34 cycles apart, none lost or doubled.
    a = $urandom; b = $urandom;
    for (int k = 0; k < 3; k++) exp_q.push_back(model(3'd0, a, b));
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs_data = a; rt_data = b;
    dones = 0; last = 0; lower = 1'b0;
    for (int c = 1; c <= 200 && dones < 3; c++) begin
      @(negedge clk);
      if (lower) begin
        start = 1'b0;
        lower = 1'b0;
      end
      if (done) begin
        dones++;
        if (dones == 1) chk("b2b_first", 64'(c), 64'd34);
        else            chk("b2b_gap", 64'(c - last), 64'd34);
        last = c;
        if (dones == 2) lower = 1'b1;
      end
    end
    start = 1'b0;
    chk("b2b_count", 64'(dones), 64'd3);
    repeat (40) @(negedge clk);
    chk("b2b_idle", 64'(busy), 64'd0);
    {hi_m, lo_m} = model(3'd0, a, b);

    // Randomised mix with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h80000000;
        2: b = 32'hFFFFFFFF;
        3: b = $urandom_range(1, 15);
        default: ;
      endcase
      if (sel < 7) begin
        o = 3'($urandom_range(0, 3));
        issue_iter(o, a, b, 1'b0);
      end else if (sel == 7) issue_mt(3'd4, a);
      else if (sel == 8)     issue_mt(3'd5, a);
      else                   issue_mt(3'($urandom_range(6, 7)), a);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
